// File: rtl/decimator_ce_if.sv
// Stream, configuration and debug signals of the decimator.
// master drives samples and config; slave is the decimator itself.
interface decimator_ce_if #(
    parameter int WIDTH    = 16,
    parameter int NCH      = 1,
    parameter int MAX_RATE = 64,
    localparam int RW      = $clog2(MAX_RATE + 1)
);
    // Handshake: the input side has no backpressure, so in_valid alone transfers
    // a sample. The output side transfers on the edge where out_valid && out_ready.
    logic [NCH*WIDTH-1:0] in_data;
    logic                 in_valid;
    logic [RW-1:0]        cfg_rate;
    logic [RW-1:0]        cfg_phase;
    logic                 cfg_load;
    logic [NCH*WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 overrun;
    logic [RW-1:0]        dbg_cnt;
    logic [RW-1:0]        dbg_rate;
    logic [RW-1:0]        dbg_phase;

    modport master (
        output in_data, in_valid, cfg_rate, cfg_phase, cfg_load, out_ready,
        input  out_data, out_valid, overrun, dbg_cnt, dbg_rate, dbg_phase
    );

    modport slave (
        input  in_data, in_valid, cfg_rate, cfg_phase, cfg_load, out_ready,
        output out_data, out_valid, overrun, dbg_cnt, dbg_rate, dbg_phase
    );
endinterface

// File: rtl/decimator_ce.sv
// Keeps one sample in every rate_q accepted inputs across NCH lockstep channels,
// presenting it as a registered valid/ready stream with a sticky overrun flag.
module decimator_ce #(
    parameter int WIDTH    = 16,
    parameter int NCH      = 1,
    parameter int MAX_RATE = 64,
    parameter int DEF_RATE = 4,
    localparam int RW      = $clog2(MAX_RATE + 1)
) (
    input logic           clk,
    input logic           rst,
    decimator_ce_if.slave bus
);
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RATE);
    localparam logic [RW-1:0] DEF_R = RW'(DEF_RATE);
    localparam logic [RW-1:0] ONE   = RW'(1);

    logic [RW-1:0]        rate_q;
    logic [RW-1:0]        phase_q;
    logic [RW-1:0]        cnt;
    logic [NCH*WIDTH-1:0] data_q;
    logic                 valid_q;
    logic                 overrun_q;

    logic [RW-1:0] rate_san;
    logic [RW-1:0] phase_san;
    logic [RW-1:0] cnt_next;
    logic          capture;
    logic          consume;

    always_comb begin
        rate_san = bus.cfg_rate;
        if (bus.cfg_rate == '0) begin
            rate_san = ONE;
        end else if (bus.cfg_rate > MAX_R) begin
            rate_san = MAX_R;
        end
        phase_san = bus.cfg_phase;
        if (bus.cfg_phase >= rate_san) begin
            phase_san = rate_san - ONE;
        end
    end

    // cnt is always below rate_q (reset and load both zero it), so equality wraps it.
    always_comb begin
        cnt_next = cnt + ONE;
        if (cnt == rate_q - ONE) begin
            cnt_next = '0;
        end
        capture = bus.in_valid && (cnt == phase_q);
        consume = valid_q && bus.out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_q    <= DEF_R;
            phase_q   <= '0;
            cnt       <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (bus.cfg_load) begin
            // The sample presented with a load is dropped; data_q is left alone.
            rate_q    <= rate_san;
            phase_q   <= phase_san;
            cnt       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                cnt <= cnt_next;
            end
            if (capture) begin
                data_q  <= bus.in_data;
                valid_q <= 1'b1;
                if (valid_q && !consume) begin
                    overrun_q <= 1'b1;
                end
            end else if (consume) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.dbg_cnt   = cnt;
    assign bus.dbg_rate  = rate_q;
    assign bus.dbg_phase = phase_q;
endmodule
